led_step_timer: RTL and testbench
=================================

Name: led_step_timer

Overview:
Upstream stage of the LED pattern module. Generates the single-cycle step-enable pulse that advances the 4-bit LED pattern register. Takes two raw board pushbuttons: one selects among four step rates, the other pauses and resumes stepping. Sits between the board buttons and the reconfigurable LED partition, in the static region.

Parameters:
DIV_BASE, 25000000, clock cycles between en pulses at speed 0; legal range >= 16.
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a button level change; >= 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_speed  input  1  raw pushbutton, active-high, asynchronous to clk
btn_pause  input  1  raw pushbutton, active-high, asynchronous to clk
en  output  1  one-cycle step pulse to the LED stage
speed  output  2  current rate select, 0 = slowest
paused  output  1  1 = stepping halted

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All flops clear on reset.
- Reset values: en=0, speed=0, paused=0, prescaler count=0, debounce FSMs in IDLE, synchronizer flops 0.
- Synchronizers: each button passes through a 2-flop synchronizer before debounce.
- Debounce FSM, one per button. States IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - IDLE -> WAIT_PRESS when the synced input is 1. The stability counter clears.
  - WAIT_PRESS: the counter increments each cycle the input is 1. If the input returns to 0, go back to IDLE. When the counter reaches DEBOUNCE_CYCLES-1 with the input at 1, go to PRESSED and emit a one-cycle press event.
  - PRESSED -> WAIT_RELEASE when the input is 0.
  - WAIT_RELEASE mirrors WAIT_PRESS. It returns to PRESSED on a glitch and to IDLE after DEBOUNCE_CYCLES stable zeros. No event is emitted on release.
  - Exactly one event per accepted press; holding the button produces no repeats.
- Event latency: 2 cycles of synchronization plus DEBOUNCE_CYCLES cycles from a clean raw edge to the event cycle.
- Speed register:
  - On a speed event, speed <= speed+1, wrapping 3 -> 0.
  - Divisor = DIV_BASE >> speed, giving DIV_BASE, /2, /4, /8.
- Pause: on a pause event, paused toggles.
- Prescaler:
  - The counter counts 0..divisor-1 and wraps to 0.
  - en=1 for exactly the cycle in which the counter equals divisor-1 and paused=0. en is a registered output.
  - While paused=1 the counter holds its value and en=0. On resume, counting continues from the held value.
  - A speed event clears the counter to 0 on the next cycle, and en is suppressed in the event cycle. The first en at the new rate follows a full new period.
- Simultaneous speed and pause events in the same cycle: both apply. The counter clears and paused toggles.
- Reset mid-debounce or mid-count: everything returns to reset values. Partial presses are discarded.
- Spacing: the minimum en spacing is DIV_BASE/8 cycles. en is never asserted on two consecutive cycles for legal DIV_BASE.

Optional Feature:
Macro STEP_SINGLE_EN.
- Defined: a speed event while paused=1 leaves speed and the counter unchanged. Instead it issues exactly one en pulse on the cycle after the event (single-step). Pause events behave normally. A speed event while running behaves as in the base behaviour.
- Undefined: speed events always change speed, and no en is ever produced while paused.

Test Plan:
(All scenarios use DIV_BASE=16, DEBOUNCE_CYCLES=4.)
1. Reset then run 100 cycles with no buttons. Required: en pulses every 16 cycles, first pulse 16 cycles after reset release; speed=0, paused=0.
2. Hold btn_speed high for 20 cycles, then release. Required: exactly one speed increment, speed=1, counter cleared; en pulses every 8 cycles afterwards. Repeat three more presses: speed goes 2, 3, 0 with periods 4, 2, 16.
3. Apply a 3-cycle btn_speed glitch. Required: no speed change.
4. Press btn_pause at count 5. Required: paused=1, no en, count held. Press again: next en arrives 10 cycles after counting resumes.
5. Press both buttons so their events land in the same cycle. Required: speed increments, paused toggles, no en in that cycle.
6. With STEP_SINGLE_EN defined: pause, then press btn_speed. Required: speed unchanged and exactly one en, the cycle after the event. Without the macro: speed increments and en stays 0.

Source files
------------

// File: rtl/led_step_timer.sv
// led_step_timer: step-enable generator for the LED pattern stage.
// Two raw pushbuttons are synchronized and debounced. btn_speed cycles the
// step rate through DIV_BASE, /2, /4, /8 and btn_pause toggles pausing.
// en is a registered single-cycle pulse.
// Optional build macro STEP_SINGLE_EN: a speed press while paused leaves
// speed and the count alone and issues exactly one en pulse (single-step).

// Per-button synchronizer plus debounce FSM. It emits one press_o pulse per
// accepted press and never emits anything on release.
module led_step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_e;

  // FSM state and stability counter, kept together so the whole debounce
  // state is visible as one struct.
  typedef struct packed {
    db_state_e       state;
    logic [DW-1:0]   cnt;
  } db_t;

  logic sync1_q, sync2_q;
  db_t  db_q, db_d;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_q.state <= IDLE;
      db_q.cnt   <= '0;
    end else begin
      db_q <= db_d;
    end
  end

  // Next-state: a level must persist for DEBOUNCE_CYCLES samples in a WAIT
  // state; any opposite sample sends it back to the settled state.
  always_comb begin
    db_d = db_q;
    case (db_q.state)
      IDLE: begin
        if (sync2_q) begin
          db_d.state = WAIT_PRESS;
          db_d.cnt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync2_q) begin
          db_d.state = IDLE;
        end else if (db_q.cnt == CNT_LAST) begin
          db_d.state = PRESSED;
        end else begin
          db_d.cnt = db_q.cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          db_d.state = WAIT_RELEASE;
          db_d.cnt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (sync2_q) begin
          db_d.state = PRESSED;
        end else if (db_q.cnt == CNT_LAST) begin
          db_d.state = IDLE;
        end else begin
          db_d.cnt = db_q.cnt + 1'b1;
        end
      end
      default: db_d.state = IDLE;
    endcase
  end

  // Output: press event in the cycle the press is accepted.
  always_comb begin
    press_o = (db_q.state == WAIT_PRESS) && sync2_q && (db_q.cnt == CNT_LAST);
  end

endmodule

module led_step_timer #(
  parameter int unsigned DIV_BASE        = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_speed,
  input  logic       btn_pause,
  output logic       en,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int unsigned CW = $clog2(DIV_BASE);
  // Terminal counts for the four rates; DIV_BASE >> speed, minus one.
  localparam logic [CW-1:0] DIV0_M1 = CW'(DIV_BASE - 1);
  localparam logic [CW-1:0] DIV1_M1 = CW'((DIV_BASE >> 1) - 1);
  localparam logic [CW-1:0] DIV2_M1 = CW'((DIV_BASE >> 2) - 1);
  localparam logic [CW-1:0] DIV3_M1 = CW'((DIV_BASE >> 3) - 1);

  logic          speed_ev, pause_ev;
  logic          step_ev, rate_ev;
  logic [CW-1:0] cnt_q, cnt_d, div_m1;
  logic [1:0]    speed_q, speed_d;
  logic          paused_q, paused_d;
  logic          en_q, en_d;

  led_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk_i   (clk),
    .rst_i   (reset),
    .btn_i   (btn_speed),
    .press_o (speed_ev)
  );

  led_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk_i   (clk),
    .rst_i   (reset),
    .btn_i   (btn_pause),
    .press_o (pause_ev)
  );

  // A speed press either changes the rate or, while paused in the
  // single-step build, requests one en pulse instead.
`ifdef STEP_SINGLE_EN
  assign step_ev = speed_ev & paused_q;
  assign rate_ev = speed_ev & ~paused_q;
`else
  assign step_ev = 1'b0;
  assign rate_ev = speed_ev;
`endif

  // Terminal count for the current rate.
  always_comb begin
    case (speed_q)
      2'd0:    div_m1 = DIV0_M1;
      2'd1:    div_m1 = DIV1_M1;
      2'd2:    div_m1 = DIV2_M1;
      default: div_m1 = DIV3_M1;
    endcase
  end

  // Next-state: rate change restarts the period and suppresses en; pause
  // freezes the count so resuming continues from the held value.
  always_comb begin
    cnt_d    = cnt_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    en_d     = 1'b0;
    if (pause_ev) begin
      paused_d = ~paused_q;
    end
    if (step_ev) begin
      en_d = 1'b1;
    end else if (rate_ev) begin
      speed_d = speed_q + 2'd1;
      cnt_d   = '0;
    end else if (!paused_q) begin
      if (cnt_q == div_m1) begin
        cnt_d = '0;
        en_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler, rate, pause and en registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      en_q     <= en_d;
    end
  end

  assign en     = en_q;
  assign speed  = speed_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_step_timer.sv
// tb_led_step_timer: scoreboard bench for led_step_timer with DIV_BASE=16,
// DEBOUNCE_CYCLES=4. Expected en cycle numbers are pushed when a button
// sequence is driven and popped when en is observed.
module tb_led_step_timer;

  localparam int DIV = 16;
  localparam int DEB = 4;
  // Negedge where a raw press is driven to the posedge where its effect lands:
  // two synchronizer flops, the IDLE sample, then DEB counting samples.
  localparam int LAT = 3 + DEB;
`ifdef STEP_SINGLE_EN
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_speed = 1'b0;
  logic       btn_pause = 1'b0;
  logic       en;
  logic [1:0] speed;
  logic       paused;

  int checks = 0;
  int failures = 0;
  int cyc;

  logic [31:0] exp_q[$];
  logic [1:0]  spd_seq [4];

  // Timing model of en: anchor (posedge after which the count is 0), divisor,
  // pause state and the posedge where the current pause began.
  int m_a, m_div, m_speed, m_pstart;
  bit m_paused;

  led_step_timer #(.DIV_BASE(DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_speed (btn_speed),
    .btn_pause (btn_pause),
    .en        (en),
    .speed     (speed),
    .paused    (paused)
  );

  // Clock and cycle counter (cyc = posedges since reset release).
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: every observed en must match the next expected cycle.
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check_eq("en_missed", cyc, exp_q.pop_front());
      end
      if (en === 1'b1) begin
        if (exp_q.size() == 0) check_eq("en_unexpected", {31'b0, en}, 32'd0);
        else                   check_eq("en_time", cyc, exp_q.pop_front());
      end else if (en !== 1'b0) begin
        check_eq("en_unknown", {31'b0, en}, 32'd0);
      end
    end
  end

  task automatic model_reset();
    m_a      = 0;
    m_div    = DIV;
    m_speed  = 0;
    m_paused = 1'b0;
    m_pstart = 0;
  endtask

  // Push en cycles in (lo, hi] under the current model.
  task automatic push_range(input int lo, input int hi);
    for (int t = lo + 1; t <= hi; t++) begin
      if (!m_paused && t > m_a && ((t - m_a) % m_div) == 0) exp_q.push_back(t);
    end
  endtask

  task automatic idle(input int len);
    push_range(cyc, cyc + len);
    repeat (len) @(negedge clk);
  endtask

  // Drive a clean press of the selected buttons; update the model at the
  // posedge where the debounced event takes effect.
  task automatic press(input bit spd, input bit pse, input int hold, input int gap);
    int n, e;
    n = cyc;
    e = n + LAT;
    push_range(n, e - 1);
    if (spd && m_paused && STEP) begin
      exp_q.push_back(e);
    end else if (spd) begin
      m_speed  = (m_speed + 1) % 4;
      m_div    = DIV >> m_speed;
      m_a      = e;
      m_pstart = e;
    end else begin
      push_range(e - 1, e);
    end
    if (pse) begin
      if (!m_paused) begin
        m_paused = 1'b1;
        m_pstart = e;
      end else begin
        m_paused = 1'b0;
        m_a = m_a + (e - m_pstart);
      end
    end
    push_range(e, n + hold + gap);
    btn_speed = spd;
    btn_pause = pse;
    repeat (hold) @(negedge clk);
    btn_speed = 1'b0;
    btn_pause = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Short speed pulse that must be rejected by the debouncer.
  task automatic glitch(input int len, input int gap);
    push_range(cyc, cyc + len + gap);
    btn_speed = 1'b1;
    repeat (len) @(negedge clk);
    btn_speed = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Idle until a press driven now lands its event in a cycle with count == target.
  task automatic align_count(input int target);
    int d;
    d = 0;
    while (((cyc + d + LAT - 1 - m_a) % m_div) != target) d++;
    idle(d);
  endtask

  initial begin
    spd_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_en", {31'b0, en}, 32'd0);
    check_eq("rst_speed", {30'b0, speed}, 32'd0);
    check_eq("rst_paused", {31'b0, paused}, 32'd0);
    reset = 1'b0;

    // Free run at the base rate.
    idle(100);
    check_eq("run_speed", {30'b0, speed}, 32'd0);
    check_eq("run_paused", {31'b0, paused}, 32'd0);

    // Four held presses: speed 1, 2, 3, 0 with periods 8, 4, 2, 16.
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 20, 20);
      check_eq("speed_step", {30'b0, speed}, {30'b0, spd_seq[i]});
      idle(40);
    end

    // Short glitch is ignored.
    glitch(3, 20);
    check_eq("glitch_speed", {30'b0, speed}, 32'd0);
    idle(10);

    // Pause with count 5 in the event cycle, hold, then resume.
    align_count(5);
    press(1'b0, 1'b1, 20, 20);
    check_eq("pause_on", {31'b0, paused}, 32'd1);
    idle(30);
    press(1'b0, 1'b1, 20, 0);
    check_eq("pause_off", {31'b0, paused}, 32'd0);
    idle(40);

    // Both events in the same cycle.
    press(1'b1, 1'b1, 20, 20);
    check_eq("both_speed", {30'b0, speed}, 32'd1);
    check_eq("both_paused", {31'b0, paused}, 32'd1);
    idle(20);
    press(1'b0, 1'b1, 20, 20);
    check_eq("both_resume", {31'b0, paused}, 32'd0);
    idle(40);

    // Speed press while paused.
    press(1'b0, 1'b1, 20, 20);
    press(1'b1, 1'b0, 20, 20);
`ifdef STEP_SINGLE_EN
    check_eq("paused_speed", {30'b0, speed}, 32'd1);
`else
    check_eq("paused_speed", {30'b0, speed}, 32'd2);
`endif
    check_eq("paused_hold", {31'b0, paused}, 32'd1);
    press(1'b0, 1'b1, 20, 20);
    idle(40);

    // Reset in the middle of a press and of a count.
    check_eq("q_drained", 32'(exp_q.size()), 32'd0);
    push_range(cyc, cyc + 5);
    btn_speed = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    btn_speed = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_en", {31'b0, en}, 32'd0);
    check_eq("mid_rst_speed", {30'b0, speed}, 32'd0);
    check_eq("mid_rst_paused", {31'b0, paused}, 32'd0);
    check_eq("mid_rst_q", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(40);
    check_eq("post_rst_speed", {30'b0, speed}, 32'd0);

    @(posedge clk);
    check_eq("q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
